sample_window_reader: RTL

Drain-side controller for the sensor input buffer FIFO. It issues single-cycle `read_enable` pulses, captures the registered FIFO output one cycle later, and packs `WINDOW_LEN` consecutive samples into a feature window. The window goes to the isolation-tree scoring stage over a valid/ready handshake. It sits between the input buffer and the tree traversal engine.

---
 rtl/sample_window_reader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sample_window_reader.sv
// rtl/sample_window_reader.sv - drains the sensor FIFO into WINDOW_LEN-sample feature windows (optional WINDOW_MINMAX_EN)
module sample_window_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int WINDOW_LEN = 4,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            fifo_data,
    input  logic                             fifo_empty,
    output logic                             read_enable,
    input  logic                             flush,
    output logic [DATA_WIDTH*WINDOW_LEN-1:0] window_data,
    output logic                             window_valid,
    input  logic                             window_ready,
`ifdef WINDOW_MINMAX_EN
    output logic [DATA_WIDTH-1:0]            window_min,
    output logic [DATA_WIDTH-1:0]            window_max,
`endif
    output logic [15:0]                      window_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t                          state;
    state_t                          state_next;
    logic [IDX_WIDTH-1:0]            idx;
    logic [DATA_WIDTH*WINDOW_LEN-1:0] window_q;
    logic [15:0]                     count_q;
    logic                            capture;
    logic                            accept;
    logic                            last_slot;

    assign last_slot    = (idx == IDX_WIDTH'(WINDOW_LEN - 1));
    assign read_enable  = (state == REQ);
    assign window_valid = (state == PRESENT);
    assign window_data  = window_q;
    assign window_count = count_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; capture and accept are suppressed by flush
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && !fifo_empty) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                state_next = flush ? IDLE : WAIT;
            end
            WAIT: begin
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    capture    = 1'b1;
                    state_next = last_slot ? PRESENT : IDLE;
                end
            end
            PRESENT: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (window_ready) begin
                    accept     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Slot index: advances per captured sample, restarts on flush or full window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= '0;
        end else if (flush) begin
            idx <= '0;
        end else if (capture) begin
            idx <= last_slot ? '0 : idx + 1'b1;
        end
    end

    // Window slots are overwritten in place; old contents are never cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            window_q <= '0;
        end else begin
            for (int k = 0; k < WINDOW_LEN; k++) begin
                if (capture && (idx == IDX_WIDTH'(k))) begin
                    window_q[k*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
                end
            end
        end
    end

    // Accepted-window counter, wraps naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_q + 16'd1;
        end
    end

`ifdef WINDOW_MINMAX_EN
    logic [DATA_WIDTH-1:0] min_q;
    logic [DATA_WIDTH-1:0] max_q;

    assign window_min = min_q;
    assign window_max = max_q;

    // Running unsigned min/max; slot 0 reloads both so a flush needs no explicit clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            min_q <= '0;
            max_q <= '0;
        end else if (capture) begin
            if (idx == '0) begin
                min_q <= fifo_data;
                max_q <= fifo_data;
            end else begin
                if (fifo_data < min_q) min_q <= fifo_data;
                if (fifo_data > max_q) max_q <= fifo_data;
            end
        end
    end
`endif

endmodule
